serializador_bits: RTL and testbench
====================================

// Module: serializador_bits
// PURPOSE
//  Transmit side of the divider's 2-bit bit-strobe interface. Takes an N-bit word through a valid/ready
//  handshake and emits it MSB first as one-cycle strobe codes on o_a.
//  o_a feeds a shift-in accumulator that is clocked on the rising edge of either o_a bit.
//  Before the first bit, o_clr pulses to clear that accumulator, so after the last strobe it holds the word.
// PARAMETERS
//  N    8  word width in bits; N >= 1
//  GAP  1  idle (2'b00) cycles after every strobe; GAP >= 1, GAP = 0 rejected at elaboration
// PORTS
//  clk      in   1    single clock; all state updates on rising edge
//  reset    in   1    asynchronous, active-low reset
//  i_dato   in   N    word to transmit; sampled only on accept
//  i_valid  in   1    word on i_dato is valid
//  o_ready  out  1    block idle, can accept a word this cycle
//  o_a      out  2    strobe code: 2'b10 = bit 1, 2'b01 = bit 0, 2'b00 = idle; 2'b11 never driven
//  o_clr    out  1    one-cycle active-high clear pulse for the receiving accumulator
//  o_busy   out  1    transfer in progress (any state except IDLE)
//  o_done   out  1    one-cycle pulse after the last bit's gap completes
// BEHAVIOUR
//  - Reset (reset = 0) asynchronously forces:
//      state = IDLE, o_a = 2'b00, o_clr = 0, o_done = 0, o_busy = 0, o_ready = 1, shift reg = 0, counters = 0.
//  - o_a, o_clr and o_done are driven directly from flops, never from combinational decode.
//    The receiver is edge-sensitive, so any glitch on these outputs corrupts data.
//  - Accept: when i_valid & o_ready are both high at a clock edge, i_dato is latched, bit count is set to N,
//    and the next state is CLR.
//  - While busy, i_valid is ignored. i_dato may change freely after accept.
//  - States and transitions:
//    IDLE    o_ready = 1; go to CLR on accept.
//    CLR     o_clr = 1 for exactly one cycle; go to STROBE.
//    STROBE  o_a = MSB ? 2'b10 : 2'b01 for exactly one cycle; shift register left by 1; bit count - 1;
//            go to GAP.
//    GAP     o_a = 2'b00 for GAP cycles; then go to DONE if bit count == 0, else back to STROBE.
//    DONE    o_done = 1 for one cycle; go to IDLE.
//  - Timing, with accept at edge 0 and outputs visible in the cycle after each edge:
//      o_clr high in cycle 1;
//      strobe k (k = 0..N-1) in cycle 2 + k*(1+GAP);
//      o_done high in cycle 2 + N*(1+GAP);
//      o_ready high again in cycle 3 + N*(1+GAP).
//  - For N = 8, GAP = 1: strobes in cycles 2, 4, ..., 16; o_done in cycle 18; o_ready in cycle 19.
//  - There is no path from DONE straight to CLR. Back-to-back words are therefore separated by the
//    one IDLE cycle.
//  - Counter widths: bit counter $clog2(N+1) bits; gap counter $clog2(GAP+1) bits; neither may wrap.
//  - N = 1: single STROBE, then GAP, then DONE.
//  - All-zero word: N strobes of 2'b01. All-ones word: N strobes of 2'b10.
//  - Reset asserted mid-transfer: outputs go to reset values immediately, with no trailing strobe.
//    The partial word is discarded. After release the block sits in IDLE with o_ready = 1.
// STRUCTURE
//  - Shared package holds:
//      strobe code constants P_N = 2'b00, P_1 = 2'b10, P_0 = 2'b01 (shared with the receiving accumulator);
//      the state encoding IDLE, CLR, STROBE, GAP, DONE.
//  - No sub-module required. FSM, shift register, bit counter and gap counter live in one module.
//  - The gap counter may be factored out as a sub-module named contador_gap if it is reused.
// TESTING
//  - Bench includes a behavioural accumulator model:
//      clears on o_clr;
//      on the rising edge of o_a[1], q = (q<<1)|1;
//      on the rising edge of o_a[0], q = q<<1.
//  1. N=8, GAP=1, send 8'hA5 -> o_a = 10,00,01,00,10,00,01,00,01,00,10,00,01,00,10,00 from cycle 2;
//     o_done in cycle 18; model q = 8'hA5.
//  2. Send 8'h00, then 8'hFF -> eight 2'b01 strobes (q = 8'h00), then eight 2'b10 strobes (q = 8'hFF);
//     o_a is never 2'b11.
//  3. i_valid held high with 8'h3C then 8'hC3 -> second word accepted exactly in cycle 19;
//     toggling i_dato while busy has no effect on the output.
//  4. Reset pulsed low at cycle 7 of an 8'hA5 transfer -> o_a = 00, o_clr = 0, o_busy = 0 the same
//     cycle; o_ready = 1 after release; next word 8'h5A delivered intact.
//  5. GAP=3, N=4, send 4'b1001 -> strobes in cycles 2, 6, 10, 14; o_done in cycle 18; q = 4'b1001.
//  6. N=1, send 1'b1 -> o_clr in cycle 1, 2'b10 in cycle 2, o_done in cycle 4.

Source files
------------

// File: rtl/serializador_bits_pkg.sv
// serializador_bits_pkg: strobe codes and FSM state encoding shared by the bit-strobe link
package serializador_bits_pkg;
  localparam logic [1:0] P_N = 2'b00;
  localparam logic [1:0] P_1 = 2'b10;
  localparam logic [1:0] P_0 = 2'b01;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_STROBE, S_GAP, S_DONE} estado_t;
endpackage

// File: rtl/serializador_bits.sv
// serializador_bits: sends an N-bit word MSB first as one-cycle strobe codes on o_a
//   clk, reset (async, active-low); i_dato/i_valid/o_ready accept handshake;
//   o_a strobe code, o_clr accumulator clear, o_busy transfer active, o_done end pulse
module serializador_bits
  import serializador_bits_pkg::*;
#(
  parameter int N   = 8,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_dato,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [1:0]   o_a,
  output logic         o_clr,
  output logic         o_busy,
  output logic         o_done
);
  localparam int BW = $clog2(N + 1);
  localparam int GW = $clog2(GAP + 1);
  if (N < 1 || GAP < 1) begin : g_param_check
    $error("serializador_bits: N and GAP must both be >= 1");
  end
  estado_t       state, state_n;
  logic [N-1:0]  sh;
  logic [BW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  logic [1:0]    a_n, code;
  logic          clr_n, done_n;
  assign code    = sh[N-1] ? P_1 : P_0;
  assign o_ready = state == S_IDLE;
  assign o_busy  = !o_ready;
  // Outputs are computed one cycle early and registered so the edge-sensitive receiver never sees a glitch.
  always_comb begin
    state_n = state;
    a_n     = P_N;
    clr_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE:   if (i_valid) begin
        state_n = S_CLR;
        clr_n   = 1'b1;
      end
      S_CLR: begin
        state_n = S_STROBE;
        a_n     = code;
      end
      S_STROBE: state_n = S_GAP;
      S_GAP:    if (gcnt == GW'(1)) begin
        state_n = bcnt == '0 ? S_DONE : S_STROBE;
        done_n  = bcnt == '0;
        a_n     = bcnt == '0 ? P_N : code;
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      o_a    <= P_N;
      o_clr  <= 1'b0;
      o_done <= 1'b0;
      sh     <= '0;
      bcnt   <= '0;
      gcnt   <= '0;
    end else begin
      state  <= state_n;
      o_a    <= a_n;
      o_clr  <= clr_n;
      o_done <= done_n;
      if (state == S_IDLE && i_valid) begin
        sh   <= i_dato;
        bcnt <= BW'(N);
      end else if (state_n == S_STROBE) begin
        sh   <= sh << 1;
        bcnt <= bcnt - 1'b1;
      end
      // Loaded with GAP on the strobe cycle, counts down to 1 on the last idle cycle.
      gcnt <= state == S_STROBE ? GW'(GAP) : state == S_GAP ? gcnt - 1'b1 : gcnt;
    end
  end
endmodule

// File: tb/tb_serializador_bits.sv
// tb_serializador_bits: checks three configurations against a cycle-offset model and an accumulator model
module tb_serializador_bits;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dato [3];
  logic       valid [3];
  logic       rdy [3];
  logic [1:0] oa [3];
  logic       clr [3];
  logic       busy [3];
  logic       done [3];
  int nn [3] = '{8, 4, 1};
  int gg [3] = '{1, 3, 1};
  int checks = 0;
  int passes = 0;
  int ecnt = 0;
  bit         active [3];
  int         acc_edge [3];
  int         prev_acc [3];
  logic [7:0] wd [3];
  logic [7:0] q [3];
  logic [1:0] pa [3];
  int         accepts [3];
  int         dones [3];
  int         done_c [3];
  typedef struct {
    int         inst;
    logic [7:0] word;
    int         exp_done;
    logic [7:0] exp_q;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  serializador_bits #(.N(8), .GAP(1)) u0 (
    .clk(clk), .reset(reset), .i_dato(dato[0]), .i_valid(valid[0]), .o_ready(rdy[0]),
    .o_a(oa[0]), .o_clr(clr[0]), .o_busy(busy[0]), .o_done(done[0]));
  serializador_bits #(.N(4), .GAP(3)) u1 (
    .clk(clk), .reset(reset), .i_dato(dato[1][3:0]), .i_valid(valid[1]), .o_ready(rdy[1]),
    .o_a(oa[1]), .o_clr(clr[1]), .o_busy(busy[1]), .o_done(done[1]));
  serializador_bits #(.N(1), .GAP(1)) u2 (
    .clk(clk), .reset(reset), .i_dato(dato[2][0:0]), .i_valid(valid[2]), .o_ready(rdy[2]),
    .o_a(oa[2]), .o_clr(clr[2]), .o_busy(busy[2]), .o_done(done[2]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] msk(input int i);
    return 8'((1 << nn[i]) - 1);
  endfunction

  always @(posedge clk) ecnt++;

  // Reference: for a word accepted at edge E, the cycle after edge E+c-1 has offset c.
  // clr at c=1, strobe k at c=2+k*(1+G), done at c=2+N*(1+G), ready again after that.
  always @(negedge clk) begin
    int c, span;
    logic [1:0] ea;
    for (int i = 0; i < 3; i++) begin
      span = 2 + nn[i] * (1 + gg[i]);
      c = ecnt - acc_edge[i];
      if (!reset || (active[i] && c > span)) active[i] = 1'b0;
      if (clr[i]) q[i] = 8'h00;
      if (oa[i][1] && !pa[i][1]) q[i] = {q[i][6:0], 1'b1};
      if (oa[i][0] && !pa[i][0]) q[i] = {q[i][6:0], 1'b0};
      pa[i] = oa[i];
      ea = 2'b00;
      if (active[i] && c >= 2 && c < span && (c - 2) % (1 + gg[i]) == 0)
        ea = wd[i][nn[i] - 1 - (c - 2) / (1 + gg[i])] ? 2'b10 : 2'b01;
      chk($sformatf("o_a[%0d]", i), int'(oa[i]), int'(ea));
      chk($sformatf("o_clr[%0d]", i), int'(clr[i]), int'(active[i] && c == 1));
      chk($sformatf("o_done[%0d]", i), int'(done[i]), int'(active[i] && c == span));
      chk($sformatf("o_busy[%0d]", i), int'(busy[i]), int'(active[i]));
      chk($sformatf("o_ready[%0d]", i), int'(rdy[i]), int'(!active[i]));
      if (done[i]) begin
        done_c[i] = c;
        dones[i]++;
      end
      if (reset && !active[i] && valid[i]) begin
        active[i]   = 1'b1;
        prev_acc[i] = acc_edge[i];
        acc_edge[i] = ecnt;
        wd[i]       = dato[i];
        accepts[i]++;
      end
    end
  end

  task automatic wait_accept(input int i);
    int a0 = accepts[i];
    int t = 0;
    while (accepts[i] == a0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk($sformatf("accept_timeout[%0d]", i), int'(accepts[i] != a0), 1);
  endtask

  task automatic send(input int i, input logic [7:0] w);
    valid[i] = 1'b1;
    dato[i]  = w;
    wait_accept(i);
    valid[i] = 1'b0;
  endtask

  // i_dato is scrambled every cycle while busy; the model uses the latched word.
  task automatic wait_done(input int i);
    int d0 = dones[i];
    int t = 0;
    while (dones[i] == d0 && t < 300) begin
      @(posedge clk);
      #1;
      dato[i] = 8'($urandom);
      t++;
    end
    chk($sformatf("done_timeout[%0d]", i), int'(dones[i] != d0), 1);
  endtask

  initial begin
    logic [7:0] w;
    int i;
    tbl[0] = '{0, 8'hA5, 18, 8'hA5};
    tbl[1] = '{0, 8'h00, 18, 8'h00};
    tbl[2] = '{0, 8'hFF, 18, 8'hFF};
    tbl[3] = '{1, 8'h09, 18, 8'h09};
    tbl[4] = '{1, 8'h06, 18, 8'h06};
    tbl[5] = '{2, 8'h01, 4, 8'h01};
    tbl[6] = '{2, 8'h00, 4, 8'h00};
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = 1'b0;
      dato[k]  = 8'h00;
    end
    #1;
    chk("reset_ready", int'(rdy[0]), 1);
    chk("reset_oa", int'(oa[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 7; k++) begin
      send(tbl[k].inst, tbl[k].word);
      wait_done(tbl[k].inst);
      chk($sformatf("done_cycle_v%0d", k), done_c[tbl[k].inst], tbl[k].exp_done);
      chk($sformatf("acc_q_v%0d", k), int'(q[tbl[k].inst] & msk(tbl[k].inst)), int'(tbl[k].exp_q));
    end
    valid[0] = 1'b1;
    dato[0]  = 8'h3C;
    wait_accept(0);
    dato[0] = 8'hC3;
    wait_accept(0);
    valid[0] = 1'b0;
    chk("b2b_accept_gap", acc_edge[0] - prev_acc[0], 19);
    wait_done(0);
    chk("b2b_q", int'(q[0]), 8'hC3);
    send(0, 8'hA5);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_busy", int'(busy[0]), 1);
    reset = 1'b0;
    #1;
    chk("rst_oa", int'(oa[0]), 0);
    chk("rst_clr", int'(clr[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_ready", int'(rdy[0]), 1);
    @(posedge clk);
    #1;
    send(0, 8'h5A);
    wait_done(0);
    chk("post_rst_q", int'(q[0]), 8'h5A);
    for (int k = 0; k < 24; k++) begin
      i = $urandom_range(2, 0);
      w = 8'($urandom) & msk(i);
      send(i, w);
      wait_done(i);
      chk($sformatf("rand_q%0d", k), int'(q[i] & msk(i)), int'(w));
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
